// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, GES bit positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_SLL    = 4'b0010,
    OP_SRA    = 4'b0011,
    OP_SRL    = 4'b0100,
    OP_XOR    = 4'b0101,
    OP_OR     = 4'b0110,
    OP_AND    = 4'b0111,
    OP_MUL    = 4'b1000,
    OP_MULH   = 4'b1001,
    OP_MULHU  = 4'b1010,
    OP_MULHSU = 4'b1011,
    OP_DIV    = 4'b1100,
    OP_DIVU   = 4'b1101,
    OP_REM    = 4'b1110,
    OP_REMU   = 4'b1111
  } alu_op_e;

  localparam int GES_G = 2;
  localparam int GES_E = 1;
  localparam int GES_S = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_HOLD = 2'b10
  } alu_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide unit: WIDTH steps on operand magnitudes, sign fix-up on the last.
// Only compiled when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  logic               busy_r, is_div_r, neg_a_r, neg_b_r, b_zero_r;
  logic [1:0]         op_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   hi_r, lo_r, opnd_r;
  logic [WIDTH-1:0]   hi_nx_s, lo_nx_s, quo_s, rem_s;
  logic [WIDTH:0]     sum_s, shl_s, diff_s;
  logic [2*WIDTH-1:0] prod_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sg);
    if (sg && x[WIDTH-1]) magnitude = -x;
    else magnitude = x;
  endfunction

  assign done = busy_r && (cnt_r == CW'(WIDTH - 1));

  // One step: hi:lo is product:multiplier when multiplying, remainder:quotient when dividing.
  always_comb begin
    sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    shl_s  = {hi_r, lo_r[WIDTH-1]};
    diff_s = shl_s - {1'b0, opnd_r};
    if (is_div_r) begin
      hi_nx_s = diff_s[WIDTH] ? shl_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
      lo_nx_s = {lo_r[WIDTH-2:0], ~diff_s[WIDTH]};
    end else begin
      hi_nx_s = sum_s[WIDTH:1];
      lo_nx_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up applied to the final step's value; a zero divisor forces an all-ones quotient.
  always_comb begin
    prod_s = neg_a_r ? -{hi_nx_s, lo_nx_s} : {hi_nx_s, lo_nx_s};
    quo_s  = b_zero_r ? {WIDTH{1'b1}} : (neg_a_r ? -lo_nx_s : lo_nx_s);
    rem_s  = neg_b_r ? -hi_nx_s : hi_nx_s;
    if (is_div_r) result = op_r[1] ? rem_s : quo_s;
    else if (op_r == 2'b00) result = prod_s[WIDTH-1:0];
    else result = prod_s[2*WIDTH-1:WIDTH];
  end

  // Operand capture on start, then one step per cycle until the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      cnt_r    <= '0;
      op_r     <= 2'b00;
      is_div_r <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      b_zero_r <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      opnd_r   <= '0;
    end else if (start) begin
      busy_r   <= 1'b1;
      cnt_r    <= '0;
      op_r     <= op;
      is_div_r <= is_div;
      hi_r     <= '0;
      if (is_div) begin
        lo_r     <= magnitude(a, !op[0]);
        opnd_r   <= magnitude(b, !op[0]);
        neg_a_r  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_b_r  <= !op[0] && a[WIDTH-1];
        b_zero_r <= (b == '0);
      end else begin
        lo_r     <= magnitude(b, op == 2'b01);
        opnd_r   <= magnitude(a, op[0]);
        neg_a_r  <= (op[0] && a[WIDTH-1]) ^ ((op == 2'b01) && b[WIDTH-1]);
        neg_b_r  <= 1'b0;
        b_zero_r <= 1'b0;
      end
    end else if (busy_r) begin
      hi_r <= hi_nx_s;
      lo_r <= lo_nx_s;
      if (done) begin
        busy_r <= 1'b0;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle base ops, iterative mul/div/rem, registered GES flag.
// Define ALU_MULDIV_EN to build the mul/div datapath; otherwise Op[3]=1 yields 0 in one cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Op,
  input  logic             CmpSigned,
  input  logic [WIDTH-1:0] Arg1,
  input  logic [WIDTH-1:0] Arg2,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [2:0]       GES
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [2:0]       ges_r;
  logic             in_ready_s, accept_s, gt_s;
  logic [2:0]       ges_s;
  logic [WIDTH-1:0] base_res_s;
  logic [SHW-1:0]   sh_amt_s;

  assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || OutReady);
  assign accept_s   = InValid && in_ready_s;
  assign sh_amt_s   = Arg2[SHW-1:0];

`ifdef ALU_MULDIV_EN
  logic             md_done_s;
  logic [WIDTH-1:0] md_result_s;
  logic [2:0]       ges_pend_r;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept_s && Op[3]),
    .op     (Op[1:0]),
    .is_div (Op[2]),
    .a      (Arg1),
    .b      (Arg2),
    .done   (md_done_s),
    .result (md_result_s)
  );
`endif

  // Base-op datapath; mul/div codes fall to zero here.
  always_comb begin
    base_res_s = '0;
    case (alu_op_e'(Op))
      OP_ADD:  base_res_s = Arg1 + Arg2;
      OP_SUB:  base_res_s = Arg1 - Arg2;
      OP_SLL:  base_res_s = Arg1 << sh_amt_s;
      OP_SRA:  base_res_s = $signed(Arg1) >>> sh_amt_s;
      OP_SRL:  base_res_s = Arg1 >> sh_amt_s;
      OP_XOR:  base_res_s = Arg1 ^ Arg2;
      OP_OR:   base_res_s = Arg1 | Arg2;
      OP_AND:  base_res_s = Arg1 & Arg2;
      default: base_res_s = '0;
    endcase
  end

  // Comparator producing a one-hot {greater, equal, smaller}.
  always_comb begin
    ges_s = 3'b000;
    gt_s  = 1'b0;
    if (CmpSigned) gt_s = $signed(Arg1) > $signed(Arg2);
    else gt_s = Arg1 > Arg2;
    if (Arg1 == Arg2) ges_s[GES_E] = 1'b1;
    else if (gt_s) ges_s[GES_G] = 1'b1;
    else ges_s[GES_S] = 1'b1;
  end

  // Control FSM and output register; a new load always wins over a consumer handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      ges_r       <= 3'b010;
`ifdef ALU_MULDIV_EN
      ges_pend_r  <= 3'b010;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
`ifdef ALU_MULDIV_EN
            if (Op[3]) begin
              ges_pend_r  <= ges_s;
              out_valid_r <= 1'b0;
              state_r     <= ST_BUSY;
            end else begin
              result_r    <= base_res_s;
              ges_r       <= ges_s;
              out_valid_r <= 1'b1;
            end
`else
            result_r    <= base_res_s;
            ges_r       <= ges_s;
            out_valid_r <= 1'b1;
`endif
          end else if (OutReady) begin
            out_valid_r <= 1'b0;
          end
        end
        ST_BUSY: begin
`ifdef ALU_MULDIV_EN
          if (md_done_s) begin
            result_r    <= md_result_s;
            ges_r       <= ges_pend_r;
            out_valid_r <= 1'b1;
            state_r     <= (out_valid_r && !OutReady) ? ST_HOLD : ST_IDLE;
          end else if (OutReady) begin
            out_valid_r <= 1'b0;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
        ST_HOLD: begin
          if (OutReady) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign InReady   = in_ready_s;
  assign OutValid  = out_valid_r;
  assign ALUResult = result_r;
  assign GES       = ges_r;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq with an arithmetic reference model and a result scoreboard.
module tb_alu_seq;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk, rst, InValid, InReady, CmpSigned, OutValid, OutReady;
  logic [3:0]  Op;
  logic [31:0] Arg1, Arg2, ALUResult;
  logic [2:0]  GES;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  ges;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady), .Op(Op),
    .CmpSigned(CmpSigned), .Arg1(Arg1), .Arg2(Arg2), .OutValid(OutValid),
    .OutReady(OutReady), .ALUResult(ALUResult), .GES(GES)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    longint sa, sb_, ub;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ub = longint'({32'h0, b});
    p = 64'h0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << b[4:0];
      4'd3:  r = $signed(a) >>> b[4:0];
      4'd4:  r = a >> b[4:0];
      4'd5:  r = a ^ b;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd8:  begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      4'd9:  begin p = sa * sb_; r = p[63:32]; end
      4'd10: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      4'd11: begin p = sa * ub; r = p[63:32]; end
      4'd12: r = (b == 32'h0) ? 32'hFFFF_FFFF : 32'(sa / sb_);
      4'd13: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      4'd14: r = (b == 32'h0) ? a : 32'(sa % sb_);
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    if (!MD && op[3]) r = 32'h0;
    return r;
  endfunction

  function automatic logic [2:0] ref_ges(input logic [31:0] a, input logic [31:0] b, input logic cs);
    if (a == b) return 3'b010;
    if (cs ? ($signed(a) > $signed(b)) : (a > b)) return 3'b100;
    return 3'b001;
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    return (MD && op[3]) ? 32 : 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic head_ready();
    if (sb.size() == 0) return 1'b0;
    return sb[0].due <= cyc;
  endfunction

  // One clock: drive at negedge, predict handshakes, update scoreboard at posedge, check at next negedge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic cs,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
    logic exp_rdy, acc, hs;
    exp_t e;
    InValid = v; Op = op; CmpSigned = cs; Arg1 = a; Arg2 = b; OutReady = ordy;
    #1;
    exp_rdy = (sb.size() == 0) || (head_ready() && ordy);
    check_val("in_ready", 32'(InReady), 32'(exp_rdy));
    acc = v && exp_rdy;
    hs = head_ready() && ordy;
    @(posedge clk);
    cyc++;
    if (hs) void'(sb.pop_front());
    if (acc) begin
      e.res = ref_res(op, a, b);
      e.ges = ref_ges(a, b, cs);
      e.due = cyc + lat_of(op);
      sb.push_back(e);
    end
    @(negedge clk);
    check_val("out_valid", 32'(OutValid), 32'(head_ready()));
    if (head_ready()) begin
      check_val("result", ALUResult, sb[0].res);
      check_val("ges", 32'(GES), 32'(sb[0].ges));
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    repeat (n) cycle(1'b0, 4'h0, 1'b0, 32'h0, 32'h0, ordy);
  endtask

  // Issue one op with the output held back, wait out its latency, check a fixed value, then drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic cs,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    cycle(1'b1, op, cs, a, b, 1'b0);
    idle(lat_of(op), 1'b0);
    check_val(tag, ALUResult, want);
    idle(1, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; InValid = 1'b0; OutReady = 1'b0; Op = 4'h0; CmpSigned = 1'b0;
    Arg1 = 32'h0; Arg2 = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 32'(OutValid), 32'h0);
    check_val("rst_result", ALUResult, 32'h0);
    check_val("rst_ges", 32'(GES), 32'h2);
    rst = 1'b0;
    sb.delete();
    cyc = 0;
    #1;
    check_val("rst_in_ready", 32'(InReady), 32'h1);
  endtask

  initial begin
    clk = 1'b0;
    do_reset();

    run_op("sub_5_7", 4'h1, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    check_val("sub_ges", 32'(GES), 32'h1);
    run_op("sra_33", 4'h3, 1'b0, 32'h8000_0000, 32'd33, 32'hC000_0000);

    for (int i = 0; i < 8; i++) cycle(1'b1, 4'h0, 1'b0, 32'(i * 3), 32'd100, 1'b1);
    idle(1, 1'b1);

    cycle(1'b1, 4'h0, 1'b0, 32'd1, 32'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'h0, 1'b0, 32'd7, 32'd8, 1'b0);
      check_val("bp_in_ready", 32'(InReady), 32'h0);
      check_val("bp_hold", ALUResult, 32'd3);
    end
    cycle(1'b1, 4'h0, 1'b0, 32'd10, 32'd20, 1'b1);
    check_val("bp_next", ALUResult, 32'd30);
    idle(1, 1'b1);

    run_op("mul", 4'h8, 1'b0, 32'hFFFF_FFFF, 32'd2, MD ? 32'hFFFF_FFFE : 32'h0);
    run_op("mulh", 4'h9, 1'b0, 32'hFFFF_FFFF, 32'd2, MD ? 32'hFFFF_FFFF : 32'h0);
    run_op("mulhu", 4'hA, 1'b0, 32'hFFFF_FFFF, 32'd2, MD ? 32'h0000_0001 : 32'h0);
    run_op("mul_3x4", 4'h8, 1'b0, 32'd3, 32'd4, MD ? 32'd12 : 32'h0);
    run_op("div_m7_2", 4'hC, 1'b0, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFD : 32'h0);
    run_op("rem_m7_2", 4'hE, 1'b0, 32'hFFFF_FFF9, 32'd2, MD ? 32'hFFFF_FFFF : 32'h0);
    run_op("divu_x_0", 4'hD, 1'b0, 32'h1234_5678, 32'h0, MD ? 32'hFFFF_FFFF : 32'h0);
    run_op("rem_x_0", 4'hE, 1'b0, 32'h1234_5678, 32'h0, MD ? 32'h1234_5678 : 32'h0);
    run_op("div_ovf", 4'hC, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, MD ? 32'h8000_0000 : 32'h0);
    run_op("rem_ovf", 4'hE, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    repeat (400)
      cycle($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            pick(), pick(), $urandom_range(0, 3) != 0);
    idle(40, 1'b1);

    // Abort a divide part-way through; nothing from it may ever surface.
    cycle(1'b1, 4'hC, 1'b1, 32'd1000, 32'd7, 1'b1);
    idle(9, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    check_val("abort_out_valid", 32'(OutValid), 32'h0);
    check_val("abort_in_ready", 32'(InReady), 32'h1);
    check_val("abort_ges", 32'(GES), 32'h2);
    idle(40, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
